// File: rtl/jtframe_rom_resp_pkg.sv
// Shared types and defaults for the frame-side SDRAM request responder.
package jtframe_rom_resp_pkg;

  // Sequencer states: prog write, refresh, two-beat read, game write-back.
  typedef enum logic [2:0] {
    IDLE,
    PWR,
    REF,
    RD0,
    W0,
    RD1,
    W1,
    GWR
  } state_t;

  // Default number of clock cycles between refresh requests.
  localparam int unsigned DEF_REF_PERIOD = 384;

endpackage

// File: rtl/jtframe_ref_timer.sv
// Free-running refresh interval counter with a sticky pending-refresh flag.
module jtframe_ref_timer
  import jtframe_rom_resp_pkg::*;
#(
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_pending
);

  localparam int unsigned   CW   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          w_wrap;

  assign w_wrap    = (r_cnt == LAST);
  assign o_pending = r_pending;

  // Count 0..REF_PERIOD-1 and wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Raise a refresh at each wrap when permitted; a new request outranks a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if (w_wrap && i_enable) begin
      r_pending <= 1'b1;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/jtframe_rom_resp.sv
// Frame-side responder: serves game SDRAM requests (32-bit reads built from two
// 16-bit backend reads, 16-bit write-backs), download writes and refreshes.
module jtframe_rom_resp
  import jtframe_rom_resp_pkg::*;
#(
  parameter int unsigned AW         = 22,
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  input  logic          prog_we,
  input  logic          sdram_req,
  input  logic [AW-1:0] sdram_addr,
  input  logic [1:0]    sdram_bank,
  input  logic          sdram_rnw,
  input  logic [1:0]    sdram_wrmask,
  input  logic [15:0]   data_write,
  input  logic          refresh_en,
  output logic          sdram_ack,
  output logic          data_rdy,
  output logic [31:0]   data_read,
  output logic          dwnld_busy,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW+1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_wmask,
  output logic          mem_ref,
  input  logic          mem_busy,
  input  logic [15:0]   mem_dout,
  input  logic          mem_dvalid
);

  state_t r_state, w_next;

  // Download write holding register
  logic          r_pwr_pend;
  logic [AW-1:0] r_paddr;
  logic [7:0]    r_pdata;
  logic [1:0]    r_pmask;
  logic [AW-1:0] w_paddr;
  logic [7:0]    w_pdata;
  logic [1:0]    w_pmask;

  // Captured game request
  logic          r_gpend;
  logic          r_grnw;
  logic [AW-1:0] r_gaddr;
  logic [1:0]    r_gbank;
  logic [15:0]   r_gdata;
  logic [1:0]    r_gmask;
  logic          w_grnw;
  logic [AW-1:0] w_gaddr;
  logic [1:0]    w_gbank;
  logic [15:0]   w_gdata;
  logic [1:0]    w_gmask;

  // Read return path
  logic [15:0]   r_low;
  logic [31:0]   r_data_read;
  logic          r_data_rdy;

  // Backend command registers and their next values
  logic          r_mem_rd, r_mem_wr, r_mem_ref;
  logic [AW+1:0] r_mem_addr;
  logic [15:0]   r_mem_din;
  logic [1:0]    r_mem_wmask;
  logic          w_mem_rd, w_mem_wr, w_mem_ref;
  logic [AW+1:0] w_mem_addr;
  logic [15:0]   w_mem_din;
  logic [1:0]    w_mem_wmask;

  logic          w_accept;
  logic          w_rd_take, w_wr_take, w_ref_take;
  logic          w_ref_pend, w_ref_clear;

  jtframe_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clear   (w_ref_clear),
    .i_enable  (refresh_en | downloading),
    .o_pending (w_ref_pend)
  );

  assign w_rd_take   = r_mem_rd  & ~mem_busy;
  assign w_wr_take   = r_mem_wr  & ~mem_busy;
  assign w_ref_take  = r_mem_ref & ~mem_busy;
  assign w_ref_clear = (r_state == REF) && w_ref_take;

  // A game request is taken only from an otherwise idle sequencer. The ack is
  // driven straight from this decision so it lands in the accepting cycle.
  assign w_accept = !rst && (r_state == IDLE) && !r_gpend && !r_pwr_pend &&
                    !w_ref_pend && sdram_req && !downloading;

  // Same-cycle captures are forwarded so the command can issue one cycle later.
  assign w_grnw  = w_accept ? sdram_rnw    : r_grnw;
  assign w_gaddr = w_accept ? sdram_addr   : r_gaddr;
  assign w_gbank = w_accept ? sdram_bank   : r_gbank;
  assign w_gdata = w_accept ? data_write   : r_gdata;
  assign w_gmask = w_accept ? sdram_wrmask : r_gmask;

  assign w_paddr = (prog_we && !r_pwr_pend) ? prog_addr : r_paddr;
  assign w_pdata = (prog_we && !r_pwr_pend) ? prog_data : r_pdata;
  assign w_pmask = (prog_we && !r_pwr_pend) ? prog_mask : r_pmask;

  assign sdram_ack  = w_accept;
  assign data_rdy   = r_data_rdy;
  assign data_read  = r_data_read;
  assign dwnld_busy = r_pwr_pend;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_ref    = r_mem_ref;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_wmask  = r_mem_wmask;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; IDLE arbitrates prog write > refresh > game request
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_pwr_pend || prog_we) begin
          w_next = PWR;
        end else if (w_ref_pend) begin
          w_next = REF;
        end else if (r_gpend || w_accept) begin
          w_next = w_grnw ? RD0 : GWR;
        end
      end
      PWR:     if (w_wr_take)  w_next = IDLE;
      REF:     if (w_ref_take) w_next = IDLE;
      RD0:     if (w_rd_take)  w_next = W0;
      W0:      if (mem_dvalid) w_next = RD1;
      RD1:     if (w_rd_take)  w_next = W1;
      W1:      if (mem_dvalid) w_next = IDLE;
      GWR:     if (w_wr_take)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command decode from the next state so commands are registered on entry
  // and stay asserted for as long as the state waits for acceptance.
  always_comb begin
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_ref   = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_din   = r_mem_din;
    w_mem_wmask = r_mem_wmask;
    case (w_next)
      PWR: begin
        w_mem_wr    = 1'b1;
        w_mem_addr  = {2'b00, w_paddr};
        w_mem_din   = {w_pdata, w_pdata};
        w_mem_wmask = w_pmask;
      end
      REF: w_mem_ref = 1'b1;
      RD0: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = {w_gbank, w_gaddr};
      end
      RD1: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = {r_gbank, r_gaddr + 1'b1};
      end
      GWR: begin
        w_mem_wr    = 1'b1;
        w_mem_addr  = {w_gbank, w_gaddr};
        w_mem_din   = w_gdata;
        w_mem_wmask = w_gmask;
      end
      default: ;
    endcase
  end

  // Backend command output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_ref   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_wmask <= '1;
    end else begin
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_mem_ref   <= w_mem_ref;
      r_mem_addr  <= w_mem_addr;
      r_mem_din   <= w_mem_din;
      r_mem_wmask <= w_mem_wmask;
    end
  end

  // Game request capture; a request acked alongside a prog write waits in r_gpend
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpend <= 1'b0;
      r_grnw  <= 1'b0;
      r_gaddr <= '0;
      r_gbank <= '0;
      r_gdata <= '0;
      r_gmask <= '1;
    end else begin
      if (w_accept) begin
        r_grnw  <= sdram_rnw;
        r_gaddr <= sdram_addr;
        r_gbank <= sdram_bank;
        r_gdata <= data_write;
        r_gmask <= sdram_wrmask;
      end
      if (w_accept && (w_next == PWR)) begin
        r_gpend <= 1'b1;
      end else if ((r_state == IDLE) && ((w_next == RD0) || (w_next == GWR))) begin
        r_gpend <= 1'b0;
      end
    end
  end

  // Download write holding register, filled in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwr_pend <= 1'b0;
      r_paddr    <= '0;
      r_pdata    <= '0;
      r_pmask    <= '1;
    end else if (prog_we) begin
      r_pwr_pend <= 1'b1;
      r_paddr    <= prog_addr;
      r_pdata    <= prog_data;
      r_pmask    <= prog_mask;
    end else if ((r_state == PWR) && w_wr_take) begin
      r_pwr_pend <= 1'b0;
    end
  end

  // Read return: low word first, then assemble and pulse data_rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_low       <= '0;
      r_data_read <= '0;
      r_data_rdy  <= 1'b0;
    end else begin
      r_data_rdy <= 1'b0;
      if ((r_state == W0) && mem_dvalid) begin
        r_low <= mem_dout;
      end
      if ((r_state == W1) && mem_dvalid) begin
        r_data_read <= {mem_dout, r_low};
        r_data_rdy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_resp.sv
// Directed bench for jtframe_rom_resp with a 2-cycle-latency word backend.
module tb_jtframe_rom_resp;

  localparam int unsigned AW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic [1:0]    sdram_bank;
  logic          sdram_rnw;
  logic [1:0]    sdram_wrmask;
  logic [15:0]   data_write;
  logic          refresh_en;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   data_read;
  logic          dwnld_busy;
  logic          mem_rd, mem_wr, mem_ref;
  logic [AW+1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_wmask;
  logic          mem_busy = 1'b0;
  logic [15:0]   mem_dout = '0;
  logic          mem_dvalid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0]   bmem [logic [23:0]];
  logic          pv [2] = '{1'b0, 1'b0};
  logic [15:0]   pd [2] = '{16'h0, 16'h0};
  int            busy_left = 0;
  logic          inject = 1'b0;
  logic [23:0]   rd_addrs [$];
  int            rdy_count = 0;

  jtframe_rom_resp #(
    .AW         (AW),
    .REF_PERIOD (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .downloading  (downloading),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_mask    (prog_mask),
    .prog_we      (prog_we),
    .sdram_req    (sdram_req),
    .sdram_addr   (sdram_addr),
    .sdram_bank   (sdram_bank),
    .sdram_rnw    (sdram_rnw),
    .sdram_wrmask (sdram_wrmask),
    .data_write   (data_write),
    .refresh_en   (refresh_en),
    .sdram_ack    (sdram_ack),
    .data_rdy     (data_rdy),
    .data_read    (data_read),
    .dwnld_busy   (dwnld_busy),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_wmask    (mem_wmask),
    .mem_ref      (mem_ref),
    .mem_busy     (mem_busy),
    .mem_dout     (mem_dout),
    .mem_dvalid   (mem_dvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rdmem(input logic [23:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 16'h0000;
  endfunction

  // Backend: busy schedule, accepts reads, returns data 2 cycles after issue
  initial begin
    forever begin
      @(negedge clk);
      mem_dvalid = pv[1];
      mem_dout   = pd[1];
      pv[1] = pv[0];
      pd[1] = pd[0];
      if (inject) begin
        mem_dvalid = 1'b1;
        mem_dout   = 16'hFFFF;
        inject     = 1'b0;
      end
      mem_busy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
      pv[0] = (mem_rd === 1'b1) && !mem_busy;
      pd[0] = rdmem(mem_addr);
    end
  end

  // Observer of read issues and data_rdy pulses
  always @(negedge clk) begin
    if (mem_rd === 1'b1) rd_addrs.push_back(mem_addr);
    if (data_rdy === 1'b1) rdy_count++;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sdram_ack === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (data_rdy === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},   sdram_ack,  1'b0);
    check({pfx, "_rdy"},   data_rdy,   1'b0);
    check({pfx, "_dread"}, data_read,  32'h0);
    check({pfx, "_busy"},  dwnld_busy, 1'b0);
    check({pfx, "_rd"},    mem_rd,     1'b0);
    check({pfx, "_wr"},    mem_wr,     1'b0);
    check({pfx, "_ref"},   mem_ref,    1'b0);
    check({pfx, "_addr"},  mem_addr,   24'h0);
    check({pfx, "_din"},   mem_din,    16'h0);
    check({pfx, "_wmask"}, mem_wmask,  2'b11);
  endtask

  initial begin
    int n, t, wr_cyc, wr_ok, ack_cnt, wr_seen, rdy0;
    logic [15:0] dl_din;
    logic [1:0]  dl_mask;
    logic [23:0] dl_addr;
    logic        dl_busy;
    int ref_t [$];

    bmem[24'h000100] = 16'h1234;
    bmem[24'h000101] = 16'hABCD;
    bmem[24'hBFFFFF] = 16'h1111;
    bmem[24'h800000] = 16'h2222;

    rst = 1'b1; downloading = 1'b0; prog_addr = '0; prog_data = '0;
    prog_mask = 2'b11; prog_we = 1'b0; sdram_req = 1'b0; sdram_addr = '0;
    sdram_bank = '0; sdram_rnw = 1'b1; sdram_wrmask = 2'b11; data_write = '0;
    refresh_en = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Basic two-word read, L = 2
    sdram_req = 1'b1; sdram_rnw = 1'b1; sdram_bank = 2'd0; sdram_addr = 22'h100;
    wait_ack(n);
    check("rd_ack_now", n, 1);
    step();
    sdram_req = 1'b0;
    #1;
    check("rd_ack_pulse", sdram_ack, 1'b0);
    wait_rdy(n);
    check("rd_latency", n, 7);
    check("rd_data", data_read, 32'hABCD1234);
    @(negedge clk);
    check("rd_rdy_pulse", data_rdy, 1'b0);

    // Address wrap inside the bank
    step();
    rd_addrs.delete();
    sdram_req = 1'b1; sdram_bank = 2'd2; sdram_addr = 22'h3FFFFF;
    wait_ack(n);
    check("wrap_ack", n, 1);
    step();
    sdram_req = 1'b0;
    wait_rdy(n);
    check("wrap_nrd", rd_addrs.size(), 2);
    if (rd_addrs.size() >= 2) begin
      check("wrap_addr0", rd_addrs[0], {2'd2, 22'h3FFFFF});
      check("wrap_addr1", rd_addrs[1], {2'd2, 22'h000000});
    end
    check("wrap_data", data_read, 32'h22221111);

    // Download write while the game holds a request
    step();
    downloading = 1'b1; sdram_req = 1'b1; sdram_bank = 2'd0; sdram_addr = 22'h100;
    prog_we = 1'b1; prog_addr = 22'd5; prog_data = 8'h5A; prog_mask = 2'b10;
    ack_cnt = 0; wr_seen = 0; dl_din = '0; dl_mask = '0; dl_addr = '0; dl_busy = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (sdram_ack === 1'b1) ack_cnt++;
      if (mem_wr === 1'b1 && wr_seen == 0) begin
        wr_seen = 1; dl_din = mem_din; dl_mask = mem_wmask; dl_addr = mem_addr; dl_busy = dwnld_busy;
      end
      step();
      prog_we = 1'b0;
    end
    check("dl_no_ack", ack_cnt, 0);
    check("dl_wr_seen", wr_seen, 1);
    check("dl_din", dl_din, 16'h5A5A);
    check("dl_wmask", dl_mask, 2'b10);
    check("dl_addr", dl_addr, 24'h000005);
    check("dl_busy", dl_busy, 1'b1);
    check("dl_busy_clr", dwnld_busy, 1'b0);
    downloading = 1'b0;
    wait_ack(n);
    check("dl_after_ack", n != 0, 1'b1);
    step();
    sdram_req = 1'b0;
    wait_rdy(n);
    check("dl_after_data", data_read, 32'hABCD1234);

    // Periodic refresh
    step();
    refresh_en = 1'b1;
    t = 0;
    repeat (40) begin
      @(negedge clk);
      t++;
      if (mem_ref === 1'b1) ref_t.push_back(t);
    end
    if (ref_t.size() < 3) begin
      check("ref_count", ref_t.size(), 3);
    end else begin
      check("ref_gap0", ref_t[1] - ref_t[0], 8);
      check("ref_gap1", ref_t[2] - ref_t[1], 8);
    end
    step();
    refresh_en = 1'b0;
    repeat (4) @(negedge clk);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_ref === 1'b1) n++;
    end
    check("ref_disabled", n, 0);

    // Game write-back with backend busy
    step();
    rdy0 = rdy_count;
    sdram_req = 1'b1; sdram_rnw = 1'b0; sdram_bank = 2'd1; sdram_addr = 22'h55;
    data_write = 16'hBEEF; sdram_wrmask = 2'b01; busy_left = 4;
    wait_ack(n);
    check("wb_ack", n, 1);
    step();
    sdram_req = 1'b0; sdram_rnw = 1'b1;
    wr_cyc = 0; wr_ok = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_wr === 1'b1) begin
        wr_cyc++;
        if (mem_addr == {2'd1, 22'h55} && mem_din == 16'hBEEF && mem_wmask == 2'b01) wr_ok++;
      end
    end
    check("wb_len", wr_cyc, 4);
    check("wb_stable", wr_ok, 4);
    check("wb_no_rdy", rdy_count - rdy0, 0);
    check("wb_hold_dread", data_read, 32'hABCD1234);

    // Reset during W0, followed by late data
    step();
    sdram_req = 1'b1; sdram_rnw = 1'b1; sdram_bank = 2'd0; sdram_addr = 22'h100;
    wait_ack(n);
    check("rr_ack", n, 1);
    step();
    sdram_req = 1'b0;
    rdy0 = rdy_count;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    inject = 1'b1;
    repeat (8) @(negedge clk);
    check("rr_no_rdy", rdy_count - rdy0, 0);
    check_reset_outputs("rr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
